sc_layer_scheduler: RTL and testbench
=====================================

SC_LAYER_SCHEDULER -- requirements
Module: sc_layer_scheduler

Interface
REQ-001 SHALL have parameter MAX_LOG2N, default 10, meaning largest supported code length exponent (N_max = 2^MAX_LOG2N).
REQ-002 SHALL have derived localparams STEP_W = MAX_LOG2N, LAYER_W = $clog2(MAX_LOG2N), LEN_W = $clog2(MAX_LOG2N+1).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_i  input  1  one-cycle request to begin a decode schedule.
REQ-006 SHALL have port log2n_i  input  LEN_W  code length exponent for this decode, sampled on accepted start.
REQ-007 SHALL have port step_ack_i  input  1  PE array finished current step's layer operation.
REQ-008 SHALL have port step_o  output  STEP_W  current step index k.
REQ-009 SHALL have port layer_o  output  LAYER_W  layer to compute for step k.
REQ-010 SHALL have port valid_o  output  1  step_o/layer_o meaningful.
REQ-011 SHALL have port last_o  output  1  current step is final (k = N-1).
REQ-012 SHALL have port busy_o  output  1  schedule in progress.
REQ-013 SHALL have port done_o  output  1  one-cycle pulse after final step acknowledged.

Function
REQ-014 SHALL implement FSM states IDLE and RUN; busy_o = valid_o = (state == RUN).
REQ-015 SHALL, in IDLE with start_i=1, latch n = clamp(log2n_i) (0 -> 1, >MAX_LOG2N -> MAX_LOG2N), set k=0, enter RUN next cycle.
REQ-016 SHALL ignore start_i while in RUN, including the cycle of the final ack.
REQ-017 SHALL compute layer_o = max(0, n-1-L), L = count of consecutive ones in k from bit n-1 downward; bits of k at or above n are zero.
REQ-018 SHALL register layer_o with k so both change on the same edge; first RUN cycle shows k=0, layer_o=n-1.
REQ-019 SHALL, in RUN with step_ack_i=1 and k < 2^n-1, increment k; new step/layer visible next cycle (1-cycle latency, back-to-back acks allowed).
REQ-020 SHALL hold step_o/layer_o stable while step_ack_i=0.
REQ-021 SHALL assert last_o combinationally when RUN and k == 2^n-1.
REQ-022 SHALL, on ack while last_o=1, go to IDLE, pulse done_o for exactly one cycle, and clear k; start_i in that done cycle is accepted.
REQ-023 SHALL ignore step_ack_i in IDLE.
REQ-024 SHALL never let k wrap past 2^n-1 regardless of extra acks.

Reset
REQ-025 SHALL on rst_n=0 immediately force state=IDLE, k=0, n=MAX_LOG2N, layer_o=0, step_o=0, valid_o=0, last_o=0, busy_o=0, done_o=0.
REQ-026 SHALL, on reset asserted mid-RUN, discard the schedule with no done_o pulse; first post-reset cycle is IDLE.

Configuration
REQ-027 SHALL support macro SC_SCHED_ABORT_EN.
REQ-028 SHALL, with SC_SCHED_ABORT_EN defined, add port abort_i input 1 and output aborted_o 1: abort_i in RUN -> IDLE next cycle, aborted_o one-cycle pulse, no done_o; abort_i wins over simultaneous step_ack_i; abort_i in IDLE ignored.
REQ-029 SHALL, without SC_SCHED_ABORT_EN, omit both ports and all abort logic; behaviour otherwise identical.

Structure
REQ-030 SHALL place state enum (IDLE, RUN) and width helper constants in package sc_sched_pkg.
REQ-031 SHALL isolate the leading-ones-to-layer mapping (REQ-017) in combinational sub-module sc_layer_calc, parametrised by MAX_LOG2N with runtime n input.

Verification
REQ-032 MAX_LOG2N=10, start with log2n_i=10, ack every cycle -> layer_o sequence for k=0,512,768,1022,1023 is 9,8,7,0,0; done_o one cycle after ack at k=1023.
REQ-033 log2n_i=3 -> layer_o over k=0..7 = 2,2,2,2,1,1,0,0; last_o only at k=7; done_o after 8 acks.
REQ-034 log2n_i=0 and log2n_i=15 -> clamp to 1 (2 steps, layers 0,0) and 10 (1024 steps).
REQ-035 ack held low 5 cycles at k=4 -> step_o/layer_o stable; start_i pulsed mid-RUN -> no effect; extra acks after done -> no effect.
REQ-036 rst_n low at k=100 -> outputs zero asynchronously, no done_o; with SC_SCHED_ABORT_EN, abort_i with ack at k=50 -> aborted_o pulse, no done_o, IDLE.

Source files
------------

// File: rtl/sc_sched_pkg.sv
// Shared types and constants for the SC decoder layer scheduler.
package sc_sched_pkg;

    localparam int DEFAULT_MAX_LOG2N = 10;
    localparam int MIN_LOG2N         = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/sc_layer_calc.sv
// Maps a step index k to the layer the PE array must compute for a code of
// length 2^n: layer = max(0, n-1-L), L = run of ones in k from bit n-1 down.
module sc_layer_calc
    import sc_sched_pkg::*;
#(
    parameter  int MAX_LOG2N = DEFAULT_MAX_LOG2N,
    localparam int STEP_W    = MAX_LOG2N,
    localparam int LAYER_W   = $clog2(MAX_LOG2N),
    localparam int LEN_W     = $clog2(MAX_LOG2N + 1)
) (
    input  logic [STEP_W-1:0]  k_i,
    input  logic [LEN_W-1:0]   n_i,
    output logic [LAYER_W-1:0] layer_o
);

    always_comb begin
        int   ones;
        int   nInt;
        logic inRun;
        ones    = 0;
        nInt    = int'(n_i);
        inRun   = 1'b1;
        layer_o = '0;
        // Bits at or above n are outside the code and never extend the run.
        for (int i = MAX_LOG2N - 1; i >= 0; i--) begin
            if (i < nInt) begin
                if (inRun && k_i[i]) begin
                    ones = ones + 1;
                end else begin
                    inRun = 1'b0;
                end
            end
        end
        if (ones < nInt) begin
            layer_o = LAYER_W'(nInt - 1 - ones);
        end
    end

endmodule

// File: rtl/sc_layer_scheduler.sv
// Step/layer sequencer for a successive-cancellation decoder PE array.
// Optional macro SC_SCHED_ABORT_EN adds abort_i / aborted_o.
module sc_layer_scheduler
    import sc_sched_pkg::*;
#(
    parameter  int MAX_LOG2N = DEFAULT_MAX_LOG2N,
    localparam int STEP_W    = MAX_LOG2N,
    localparam int LAYER_W   = $clog2(MAX_LOG2N),
    localparam int LEN_W     = $clog2(MAX_LOG2N + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [LEN_W-1:0]   log2n_i,
    input  logic               step_ack_i,
`ifdef SC_SCHED_ABORT_EN
    input  logic               abort_i,
    output logic               aborted_o,
`endif
    output logic [STEP_W-1:0]  step_o,
    output logic [LAYER_W-1:0] layer_o,
    output logic               valid_o,
    output logic               last_o,
    output logic               busy_o,
    output logic               done_o
);

    sched_state_t       r_state;
    sched_state_t       w_stateNext;
    logic [STEP_W-1:0]  r_k;
    logic [STEP_W-1:0]  w_kNext;
    logic [LEN_W-1:0]   r_n;
    logic [LEN_W-1:0]   w_nNext;
    logic [LEN_W-1:0]   w_nClamped;
    logic [LAYER_W-1:0] r_layer;
    logic [LAYER_W-1:0] w_layerNext;
    logic [STEP_W-1:0]  w_lastK;
    logic               w_last;
    logic               r_done;
    logic               w_doneNext;
`ifdef SC_SCHED_ABORT_EN
    logic               r_aborted;
    logic               w_abortedNext;
`endif

    always_comb begin
        w_nClamped = log2n_i;
        if (log2n_i == '0) begin
            w_nClamped = LEN_W'(MIN_LOG2N);
        end else if (log2n_i > LEN_W'(MAX_LOG2N)) begin
            w_nClamped = LEN_W'(MAX_LOG2N);
        end
    end

    assign w_lastK = {STEP_W{1'b1}} >> (LEN_W'(MAX_LOG2N) - r_n);
    assign w_last  = (r_state == RUN) && (r_k == w_lastK);

    always_comb begin
        w_stateNext = r_state;
        w_kNext     = r_k;
        w_nNext     = r_n;
        w_doneNext  = 1'b0;
`ifdef SC_SCHED_ABORT_EN
        w_abortedNext = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_stateNext = RUN;
                    w_kNext     = '0;
                    w_nNext     = w_nClamped;
                end
            end
            RUN: begin
`ifdef SC_SCHED_ABORT_EN
                if (abort_i) begin
                    w_stateNext   = IDLE;
                    w_kNext       = '0;
                    w_abortedNext = 1'b1;
                end else
`endif
                if (step_ack_i) begin
                    if (w_last) begin
                        w_stateNext = IDLE;
                        w_kNext     = '0;
                        w_doneNext  = 1'b1;
                    end else begin
                        w_kNext = r_k + STEP_W'(1);
                    end
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    // Layer is computed from the next k so it lands in the same edge as step_o.
    sc_layer_calc #(
        .MAX_LOG2N(MAX_LOG2N)
    ) u_layerCalc (
        .k_i    (w_kNext),
        .n_i    (w_nNext),
        .layer_o(w_layerNext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_n     <= LEN_W'(MAX_LOG2N);
            r_layer <= '0;
            r_done  <= 1'b0;
`ifdef SC_SCHED_ABORT_EN
            r_aborted <= 1'b0;
`endif
        end else begin
            r_state <= w_stateNext;
            r_k     <= w_kNext;
            r_n     <= w_nNext;
            r_layer <= (w_stateNext == RUN) ? w_layerNext : '0;
            r_done  <= w_doneNext;
`ifdef SC_SCHED_ABORT_EN
            r_aborted <= w_abortedNext;
`endif
        end
    end

    assign step_o  = r_k;
    assign layer_o = r_layer;
    assign valid_o = (r_state == RUN);
    assign busy_o  = (r_state == RUN);
    assign last_o  = w_last;
    assign done_o  = r_done;
`ifdef SC_SCHED_ABORT_EN
    assign aborted_o = r_aborted;
`endif

endmodule

// File: tb/tb_sc_layer_scheduler.sv
// Directed self-checking bench for sc_layer_scheduler (MAX_LOG2N = 10).
module tb_sc_layer_scheduler;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] log2n;
    logic       stepAck;
    logic [9:0] step;
    logic [3:0] layer;
    logic       valid;
    logic       last;
    logic       busy;
    logic       done;
`ifdef SC_SCHED_ABORT_EN
    logic       abort;
    logic       aborted;
`endif

    int checkCount = 0;
    int passCount  = 0;
    int tbl3[8]    = '{2, 2, 2, 2, 1, 1, 0, 0};

    sc_layer_scheduler #(
        .MAX_LOG2N(10)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start),
        .log2n_i   (log2n),
        .step_ack_i(stepAck),
`ifdef SC_SCHED_ABORT_EN
        .abort_i   (abort),
        .aborted_o (aborted),
`endif
        .step_o    (step),
        .layer_o   (layer),
        .valid_o   (valid),
        .last_o    (last),
        .busy_o    (busy),
        .done_o    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, then samples 1 time unit after the edge.
    task automatic applyStimulus(input logic s, input logic [3:0] n, input logic a);
        start   = s;
        log2n   = n;
        stepAck = a;
        @(posedge clk);
        #1;
        start   = 1'b0;
        stepAck = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n   = 1'b1;
        start   = 1'b0;
        log2n   = 4'd0;
        stepAck = 1'b0;
`ifdef SC_SCHED_ABORT_EN
        abort   = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset valid", int'(valid), 0);
        checkOutput("reset busy",  int'(busy),  0);
        checkOutput("reset step",  int'(step),  0);
        checkOutput("reset layer", int'(layer), 0);
        checkOutput("reset last",  int'(last),  0);
        checkOutput("reset done",  int'(done),  0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full-length code, ack every cycle.
        applyStimulus(1'b1, 4'd10, 1'b0);
        checkOutput("n10 valid k0", int'(valid), 1);
        checkOutput("n10 busy k0",  int'(busy),  1);
        checkOutput("n10 step k0",  int'(step),  0);
        checkOutput("n10 layer k0", int'(layer), 9);
        checkOutput("n10 last k0",  int'(last),  0);
        for (int i = 1; i <= 1023; i++) begin
            applyStimulus(1'b0, 4'd0, 1'b1);
            if (i == 512) begin
                checkOutput("n10 step k512",  int'(step),  512);
                checkOutput("n10 layer k512", int'(layer), 8);
            end
            if (i == 768) checkOutput("n10 layer k768", int'(layer), 7);
            if (i == 1022) begin
                checkOutput("n10 layer k1022", int'(layer), 0);
                checkOutput("n10 last k1022",  int'(last),  0);
            end
            if (i == 1023) begin
                checkOutput("n10 step k1023",  int'(step),  1023);
                checkOutput("n10 layer k1023", int'(layer), 0);
                checkOutput("n10 last k1023",  int'(last),  1);
                checkOutput("n10 done early",  int'(done),  0);
            end
        end
        applyStimulus(1'b0, 4'd0, 1'b1);
        checkOutput("n10 done",       int'(done),  1);
        checkOutput("n10 idle valid", int'(valid), 0);
        checkOutput("n10 idle step",  int'(step),  0);
        applyStimulus(1'b0, 4'd0, 1'b1);
        checkOutput("extra ack done",  int'(done),  0);
        checkOutput("extra ack valid", int'(valid), 0);
        checkOutput("extra ack step",  int'(step),  0);

        // n = 3 with an ack stall and a stray start at k = 4.
        applyStimulus(1'b1, 4'd3, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("n3 step k%0d", i),  int'(step),  i);
            checkOutput($sformatf("n3 layer k%0d", i), int'(layer), tbl3[i]);
            checkOutput($sformatf("n3 last k%0d", i),  int'(last),  (i == 7) ? 1 : 0);
            if (i == 4) begin
                for (int j = 0; j < 5; j++) begin
                    applyStimulus(j == 2, 4'd7, 1'b0);
                    checkOutput("n3 stall step",  int'(step),  4);
                    checkOutput("n3 stall layer", int'(layer), 1);
                    checkOutput("n3 stall valid", int'(valid), 1);
                end
            end
            applyStimulus(1'b0, 4'd0, 1'b1);
        end
        checkOutput("n3 done",       int'(done),  1);
        checkOutput("n3 idle valid", int'(valid), 0);

        // Start in the done cycle with log2n = 0 clamps to n = 1.
        applyStimulus(1'b1, 4'd0, 1'b0);
        checkOutput("n1 valid k0", int'(valid), 1);
        checkOutput("n1 done k0",  int'(done),  0);
        checkOutput("n1 step k0",  int'(step),  0);
        checkOutput("n1 layer k0", int'(layer), 0);
        checkOutput("n1 last k0",  int'(last),  0);
        applyStimulus(1'b0, 4'd0, 1'b1);
        checkOutput("n1 step k1",  int'(step),  1);
        checkOutput("n1 layer k1", int'(layer), 0);
        checkOutput("n1 last k1",  int'(last),  1);
        applyStimulus(1'b0, 4'd0, 1'b1);
        checkOutput("n1 done", int'(done), 1);

        // log2n = 15 clamps to 10.
        applyStimulus(1'b1, 4'd15, 1'b0);
        checkOutput("n15 layer k0", int'(layer), 9);
        checkOutput("n15 last k0",  int'(last),  0);
        for (int i = 1; i <= 1023; i++) begin
            applyStimulus(1'b0, 4'd0, 1'b1);
            if (i == 1022) checkOutput("n15 last k1022", int'(last), 0);
        end
        checkOutput("n15 step k1023", int'(step), 1023);
        checkOutput("n15 last k1023", int'(last), 1);
        applyStimulus(1'b0, 4'd0, 1'b1);
        checkOutput("n15 done", int'(done), 1);

        // Asynchronous reset in the middle of a schedule.
        applyStimulus(1'b1, 4'd10, 1'b0);
        for (int i = 1; i <= 100; i++) applyStimulus(1'b0, 4'd0, 1'b1);
        checkOutput("rst pre step",  int'(step),  100);
        checkOutput("rst pre layer", int'(layer), 9);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst mid valid", int'(valid), 0);
        checkOutput("rst mid busy",  int'(busy),  0);
        checkOutput("rst mid step",  int'(step),  0);
        checkOutput("rst mid layer", int'(layer), 0);
        checkOutput("rst mid last",  int'(last),  0);
        checkOutput("rst mid done",  int'(done),  0);
        @(posedge clk);
        #1;
        checkOutput("rst hold done", int'(done), 0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b1);
        checkOutput("rst post valid", int'(valid), 0);
        checkOutput("rst post done",  int'(done),  0);
        checkOutput("rst post step",  int'(step),  0);

`ifdef SC_SCHED_ABORT_EN
        applyStimulus(1'b1, 4'd10, 1'b0);
        for (int i = 1; i <= 50; i++) applyStimulus(1'b0, 4'd0, 1'b1);
        checkOutput("abort pre step", int'(step), 50);
        abort = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b1);
        abort = 1'b0;
        checkOutput("abort pulse", int'(aborted), 1);
        checkOutput("abort done",  int'(done),    0);
        checkOutput("abort valid", int'(valid),   0);
        checkOutput("abort step",  int'(step),    0);
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkOutput("abort pulse end", int'(aborted), 0);
        abort = 1'b1;
        applyStimulus(1'b0, 4'd0, 1'b0);
        abort = 1'b0;
        checkOutput("abort idle pulse", int'(aborted), 0);
        checkOutput("abort idle valid", int'(valid),   0);
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
